// File: rtl/regfile_mp.sv
// Register file with one write port, two combinational read ports, pending bits and a clear sequencer.
// Define REGFILE_BYPASS_EN to forward an accepted write to the read ports in the same cycle.
module regfile_mp #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           w_data,
  input  logic [$clog2(DEPTH)-1:0]   w_addr,
  input  logic                       w_en,
  input  logic [$clog2(DEPTH)-1:0]   ra_addr,
  output logic [WIDTH-1:0]           ra_data,
  input  logic [$clog2(DEPTH)-1:0]   rb_addr,
  output logic [WIDTH-1:0]           rb_data,
  input  logic                       pend_set,
  input  logic [$clog2(DEPTH)-1:0]   pend_addr,
  output logic                       pend_a,
  output logic                       pend_b,
  input  logic                       clr_start,
  output logic                       busy,
  output logic                       clr_done
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t           state_q, state_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;
  logic             wr_acc;

  assign busy     = (state_q != IDLE);
  assign clr_done = (state_q == DONE);
  assign wr_acc   = w_en & ~busy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        regs_d[cnt_q[AW-1:0]] = '0;
        pend_d[cnt_q[AW-1:0]] = 1'b0;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == (AW+1)'(DEPTH-1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (wr_acc) begin
      regs_d[w_addr] = w_data;
      pend_d[w_addr] = 1'b0;
    end
    // Applied after the write clear so a same-address set wins.
    if (pend_set && !busy) pend_d[pend_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic hit_a, hit_b;
  assign hit_a   = wr_acc && (ra_addr == w_addr);
  assign hit_b   = wr_acc && (rb_addr == w_addr);
  assign ra_data = hit_a ? w_data : regs_q[ra_addr];
  assign rb_data = hit_b ? w_data : regs_q[rb_addr];
  assign pend_a  = hit_a ? 1'b0 : pend_q[ra_addr];
  assign pend_b  = hit_b ? 1'b0 : pend_q[rb_addr];
`else
  assign ra_data = regs_q[ra_addr];
  assign rb_data = regs_q[rb_addr];
  assign pend_a  = pend_q[ra_addr];
  assign pend_b  = pend_q[rb_addr];
`endif

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a 16x8 instance for the main behaviour and a 32x32 instance for the long clear.
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [15:0] w_data = '0;
  logic [2:0]  w_addr = '0, ra_addr = '0, rb_addr = '0, pend_addr = '0;
  logic        w_en = 1'b0, pend_set = 1'b0, clr_start = 1'b0;
  logic [15:0] ra_data, rb_data;
  logic        pend_a, pend_b, busy, clr_done;

  logic [31:0] b_w_data = '0;
  logic [4:0]  b_w_addr = '0, b_ra_addr = '0, b_rb_addr = '0, b_pend_addr = '0;
  logic        b_w_en = 1'b0, b_pend_set = 1'b0, b_clr_start = 1'b0;
  logic [31:0] b_ra_data, b_rb_data;
  logic        b_pend_a, b_pend_b, b_busy, b_clr_done;

  int vectors = 0;
  int miscompares = 0;

  regfile_mp #(.WIDTH(16), .DEPTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .w_data(w_data), .w_addr(w_addr), .w_en(w_en),
    .ra_addr(ra_addr), .ra_data(ra_data), .rb_addr(rb_addr), .rb_data(rb_data),
    .pend_set(pend_set), .pend_addr(pend_addr), .pend_a(pend_a), .pend_b(pend_b),
    .clr_start(clr_start), .busy(busy), .clr_done(clr_done)
  );

  regfile_mp #(.WIDTH(32), .DEPTH(32)) u_big (
    .clk(clk), .rst_n(rst_n), .w_data(b_w_data), .w_addr(b_w_addr), .w_en(b_w_en),
    .ra_addr(b_ra_addr), .ra_data(b_ra_data), .rb_addr(b_rb_addr), .rb_data(b_rb_data),
    .pend_set(b_pend_set), .pend_addr(b_pend_addr), .pend_a(b_pend_a), .pend_b(b_pend_b),
    .clr_start(b_clr_start), .busy(b_busy), .clr_done(b_clr_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int done_cyc;
    int done_cnt;

    // Reset state, before any clock edge
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", clr_done, 0);
    chk("rst_ra", ra_data, 0);
    chk("rst_rb", rb_data, 0);
    chk("rst_pa", pend_a, 0);
    chk("rst_pb", pend_b, 0);
    #9 rst_n = 1'b1;

    // Basic writes and dual reads
    w_en = 1; w_addr = 0; w_data = 16'd5030; tick();
    w_addr = 5; w_data = 16'hFFE2; tick();
    w_addr = 7; w_data = 16'h88DC; tick();
    w_en = 0;
    ra_addr = 0; rb_addr = 5; #1;
    chk("rd_r0", ra_data, 16'd5030);
    chk("rd_r5", rb_data, 16'hFFE2);
    ra_addr = 7; #1;
    chk("rd_r7", ra_data, 16'h88DC);

    // Same-cycle read of the address being written
    ra_addr = 2; w_en = 1; w_addr = 2; w_data = 16'hABCD; #1;
`ifdef REGFILE_BYPASS_EN
    chk("byp_pre", ra_data, 16'hABCD);
`else
    chk("byp_pre", ra_data, 16'h0000);
`endif
    tick();
    w_en = 0; #1;
    chk("byp_post", ra_data, 16'hABCD);

    // Pending bits
    ra_addr = 3; rb_addr = 3; pend_set = 1; pend_addr = 3; #1;
    chk("pend_pre", pend_a, 0);
    tick();
    pend_set = 0; #1;
    chk("pend_set", pend_a, 1);
    w_en = 1; w_addr = 3; w_data = 16'h7FFF; tick();
    w_en = 0; #1;
    chk("pend_clr", pend_a, 0);
    chk("r3_val", ra_data, 16'h7FFF);
    pend_set = 1; pend_addr = 3; w_en = 1; w_addr = 3; w_data = 16'h1234; tick();
    pend_set = 0; w_en = 0; #1;
    chk("pend_win_a", pend_a, 1);
    chk("pend_win_b", pend_b, 1);
    chk("r3_val2", ra_data, 16'h1234);

    // Fill and clear
    for (int i = 0; i < 8; i++) begin
      w_en = 1; w_addr = 3'(i); w_data = 16'(16'h1111 * i); tick();
    end
    w_en = 0; pend_set = 1; pend_addr = 6; tick();
    pend_set = 0;
    ra_addr = 5; rb_addr = 1;
    clr_start = 1; tick();
    clr_start = 0;
    n = 0; done_cyc = 0; done_cnt = 0;
    while (busy && n < 20) begin
      if (clr_done) begin done_cyc = n + 1; done_cnt++; end
      if (n == 3) begin
        chk("mid_uncleared", ra_data, 16'h5555);
        chk("mid_cleared", rb_data, 16'h0000);
      end
      w_en = (n == 1) || (n == 8);
      w_addr = (n == 8) ? 3'd7 : 3'd0;
      w_data = (n == 8) ? 16'h5A5A : 16'hBEEF;
      pend_set = (n == 2); pend_addr = 0;
      clr_start = (n == 4);
      tick();
      n++;
    end
    w_en = 0; pend_set = 0; clr_start = 0;
    chk("clr_busy_cycles", n, 9);
    chk("clr_done_cycle", done_cyc, 9);
    chk("clr_done_count", done_cnt, 1);
    chk("clr_idle", busy, 0);
    for (int i = 0; i < 8; i++) begin
      ra_addr = 3'(i); #1;
      chk("clr_zero", ra_data, 16'h0000);
      chk("clr_pend", pend_a, 0);
    end

    // Reset during clear
    w_en = 1; w_addr = 6; w_data = 16'h6666; tick();
    w_addr = 5; w_data = 16'h5555; tick();
    w_en = 0; ra_addr = 6; rb_addr = 5;
    clr_start = 1; tick();
    clr_start = 0;
    tick(); tick(); tick();
    chk("abort_busy_pre", busy, 1);
    rst_n = 0; #1;
    chk("abort_busy", busy, 0);
    chk("abort_ra", ra_data, 0);
    chk("abort_rb", rb_data, 0);
    @(negedge clk);
    rst_n = 1;
    w_en = 1; w_addr = 6; w_data = 16'h8000; tick();
    w_en = 0; #1;
    chk("post_rst_wr", ra_data, 16'h8000);
    chk("post_rst_busy", busy, 0);

    // Wide, deep instance
    b_w_en = 1; b_w_addr = 31; b_w_data = 32'hDEADBEEF; tick();
    b_w_en = 0; b_ra_addr = 31; #1;
    chk("big_wr", b_ra_data, 32'hDEADBEEF);
    b_clr_start = 1; tick();
    b_clr_start = 0;
    n = 0; done_cyc = 0;
    while (b_busy && n < 60) begin
      if (b_clr_done) done_cyc = n + 1;
      if (n == 31) chk("big_r31_before", b_ra_data, 32'hDEADBEEF);
      if (n == 32) chk("big_r31_after", b_ra_data, 32'h0);
      tick();
      n++;
    end
    chk("big_busy_cycles", n, 33);
    chk("big_done_cycle", done_cyc, 33);
    chk("big_pend", b_pend_a, 0);
    chk("big_rb", b_rb_data, 32'h0);
    chk("big_pb", b_pend_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
